player_cmd_arbiter: RTL

//   Sole writer of MP3 player control state: song index, pause, volume level/word, effect word.

---
 rtl/player_cmd_if.sv | 31 +++
 rtl/player_cmd_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/player_cmd_if.sv
// Request/status bundle between the command sources (UART, buttons, song-end detect)
// and the player control arbiter.
interface player_cmd_if;
  logic        fin_song;
  logic [4:0]  btn_req;
  logic        bt_valid;
  logic [7:0]  bt_cmd;
  logic [2:0]  song_sel;
  logic        pause;
  logic [3:0]  vol_level;
  logic [15:0] o_vol;
  logic [15:0] effect;
  logic        next_pulse;
  logic        pre_pulse;
  logic        vp_pulse;
  logic        vd_pulse;
  logic        busy;
  logic        cmd_drop;

  modport master (
    output fin_song, btn_req, bt_valid, bt_cmd,
    input  song_sel, pause, vol_level, o_vol, effect,
    input  next_pulse, pre_pulse, vp_pulse, vd_pulse, busy, cmd_drop
  );

  modport slave (
    input  fin_song, btn_req, bt_valid, bt_cmd,
    output song_sel, pause, vol_level, o_vol, effect,
    output next_pulse, pre_pulse, vp_pulse, vd_pulse, busy, cmd_drop
  );
endinterface

// File: rtl/player_cmd_arbiter.sv
// Sole writer of the MP3 player control state. Auto-advance, button and bluetooth
// requests wait in one-deep slots and are applied one at a time, with a hold-off after track/volume changes.
module player_cmd_arbiter #(
  parameter int SONG_NUM = 4,
  parameter int VOL_MAX  = 8,
  parameter int HOLDOFF  = 50000000
) (
  input logic         clk,
  input logic         rst_n,
  player_cmd_if.slave bus
);
  localparam int                 CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [2:0]         SONG_LAST = 3'(SONG_NUM - 1);
  localparam logic [3:0]         VOL_TOP   = 4'(VOL_MAX);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    C_PAUSE = 3'd0, C_NEXT = 3'd1, C_PRE = 3'd2, C_VP = 3'd3,
    C_VD = 3'd4, C_EFF0 = 3'd5, C_EFF1 = 3'd6, C_EFF2 = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_e;

  // Bit 3 flags a code that exists in the bluetooth command table.
  function automatic logic [3:0] bt_decode(input logic [7:0] code);
    case (code)
      8'h01:   bt_decode = {1'b1, C_PAUSE};
      8'h02:   bt_decode = {1'b1, C_NEXT};
      8'h03:   bt_decode = {1'b1, C_PRE};
      8'h04:   bt_decode = {1'b1, C_VP};
      8'h05:   bt_decode = {1'b1, C_VD};
      8'h40:   bt_decode = {1'b1, C_EFF0};
      8'h41:   bt_decode = {1'b1, C_EFF1};
      8'h42:   bt_decode = {1'b1, C_EFF2};
      default: bt_decode = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] vol_byte(input logic [3:0] lvl);
    if (lvl == VOL_TOP) vol_byte = 8'hFC;
    else                vol_byte = {4'd0, lvl} * 8'd14;
  endfunction

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  cmd_e             cmd_r, btn_slot_r, bt_slot_r, btn_cmd_s;
  logic             fin_exec_r, fin_full_r, btn_full_r, bt_full_r;
  logic [2:0]       song_r;
  logic             pause_r, busy_r, drop_r;
  logic [3:0]       vol_r;
  logic [15:0]      o_vol_r, effect_r;
  logic             next_r, pre_r, vp_r, vd_r;

  logic       btn_any_s, btn_multi_s, bt_ok_s, drop_s, hold_cmd_s;
  logic       fin_take_s, btn_take_s, bt_take_s, gnt_fin_s, gnt_btn_s, gnt_bt_s;
  logic [3:0] bt_dec_s, vol_up_s, vol_dn_s;
  logic [2:0] song_inc_s, song_dec_s;

  // Lowest set button bit selects the button command.
  always_comb begin
    btn_cmd_s = C_PAUSE;
    if (bus.btn_req[0])      btn_cmd_s = C_PAUSE;
    else if (bus.btn_req[1]) btn_cmd_s = C_NEXT;
    else if (bus.btn_req[2]) btn_cmd_s = C_PRE;
    else if (bus.btn_req[3]) btn_cmd_s = C_VP;
    else                     btn_cmd_s = C_VD;
  end

  assign btn_any_s   = |bus.btn_req;
  assign btn_multi_s = (bus.btn_req & (bus.btn_req - 5'd1)) != 5'd0;
  assign bt_dec_s    = bt_decode(bus.bt_cmd);
  assign bt_ok_s     = bt_dec_s[3];
  assign fin_take_s  = bus.fin_song & ~fin_full_r;
  assign btn_take_s  = btn_any_s & ~btn_full_r;
  assign bt_take_s   = bus.bt_valid & bt_ok_s & ~bt_full_r;
  assign drop_s      = (bus.fin_song & fin_full_r) | (btn_any_s & (btn_full_r | btn_multi_s)) |
                       (bus.bt_valid & (~bt_ok_s | bt_full_r));
  assign gnt_fin_s   = (state_r == IDLE) & fin_full_r;
  assign gnt_btn_s   = (state_r == IDLE) & ~fin_full_r & btn_full_r;
  assign gnt_bt_s    = (state_r == IDLE) & ~fin_full_r & ~btn_full_r & bt_full_r;
  assign vol_up_s    = (vol_r == 4'd0) ? 4'd0 : vol_r - 4'd1;
  assign vol_dn_s    = (vol_r >= VOL_TOP) ? VOL_TOP : vol_r + 4'd1;
  assign song_inc_s  = (song_r == SONG_LAST) ? 3'd0 : song_r + 3'd1;
  assign song_dec_s  = (song_r == 3'd0) ? SONG_LAST : song_r - 3'd1;
  assign hold_cmd_s  = (cmd_r == C_NEXT) | (cmd_r == C_PRE) | (cmd_r == C_VP) | (cmd_r == C_VD);

  // Pending slots: a capture only happens into an empty slot, a grant only empties a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_full_r <= 1'b0;
      btn_full_r <= 1'b0;
      bt_full_r  <= 1'b0;
      btn_slot_r <= C_PAUSE;
      bt_slot_r  <= C_PAUSE;
      drop_r     <= 1'b0;
    end else begin
      if (fin_take_s)     fin_full_r <= 1'b1;
      else if (gnt_fin_s) fin_full_r <= 1'b0;
      if (btn_take_s) begin
        btn_full_r <= 1'b1;
        btn_slot_r <= btn_cmd_s;
      end else if (gnt_btn_s) begin
        btn_full_r <= 1'b0;
      end
      if (bt_take_s) begin
        bt_full_r <= 1'b1;
        bt_slot_r <= cmd_e'(bt_dec_s[2:0]);
      end else if (gnt_bt_s) begin
        bt_full_r <= 1'b0;
      end
      drop_r <= drop_s;
    end
  end

  // Grant / execute / hold-off sequencer and all player state outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      cmd_r      <= C_PAUSE;
      fin_exec_r <= 1'b0;
      song_r     <= 3'd0;
      pause_r    <= 1'b1;
      vol_r      <= 4'd0;
      o_vol_r    <= 16'd0;
      effect_r   <= 16'd0;
      busy_r     <= 1'b0;
      next_r     <= 1'b0;
      pre_r      <= 1'b0;
      vp_r       <= 1'b0;
      vd_r       <= 1'b0;
    end else begin
      next_r <= 1'b0;
      pre_r  <= 1'b0;
      vp_r   <= 1'b0;
      vd_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fin_full_r | btn_full_r | bt_full_r) begin
            state_r    <= EXEC;
            busy_r     <= 1'b1;
            fin_exec_r <= fin_full_r;
            cmd_r      <= fin_full_r ? C_NEXT : (btn_full_r ? btn_slot_r : bt_slot_r);
          end
        end
        EXEC: begin
          case (cmd_r)
            C_PAUSE: pause_r <= ~pause_r;
            C_NEXT: begin
              song_r <= song_inc_s;
              next_r <= ~fin_exec_r;
            end
            C_PRE: begin
              song_r <= song_dec_s;
              pre_r  <= 1'b1;
            end
            C_VP: begin
              vol_r   <= vol_up_s;
              o_vol_r <= {vol_byte(vol_up_s), vol_byte(vol_up_s)};
              vp_r    <= 1'b1;
            end
            C_VD: begin
              vol_r   <= vol_dn_s;
              o_vol_r <= {vol_byte(vol_dn_s), vol_byte(vol_dn_s)};
              vd_r    <= 1'b1;
            end
            C_EFF0:  effect_r <= 16'h0000;
            C_EFF1:  effect_r <= 16'h0707;
            C_EFF2:  effect_r <= 16'hF0F0;
            default: effect_r <= effect_r;
          endcase
          cnt_r   <= '0;
          state_r <= hold_cmd_s ? HOLD : IDLE;
          busy_r  <= hold_cmd_s;
        end
        HOLD: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.song_sel   = song_r;
  assign bus.pause      = pause_r;
  assign bus.vol_level  = vol_r;
  assign bus.o_vol      = o_vol_r;
  assign bus.effect     = effect_r;
  assign bus.next_pulse = next_r;
  assign bus.pre_pulse  = pre_r;
  assign bus.vp_pulse   = vp_r;
  assign bus.vd_pulse   = vd_r;
  assign bus.busy       = busy_r;
  assign bus.cmd_drop   = drop_r;
endmodule
